// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of unmapped pregs, 2 allocs / 3 releases per cycle.
// Define FREE_LIST_CHECK_EN to add an in-pool bitmap that rejects double frees.
module preg_free_list #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 3,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
    parameter int PREG_W    = $clog2(NUM_PREGS),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [ALLOC_W-1:0]          i_alloc_req,
    output logic                        o_alloc_grant,
    output logic [ALLOC_W*PREG_W-1:0]   o_alloc_preg,
    output logic                        o_stall,
    input  logic [FREE_W-1:0]           i_free_valid,
    input  logic [FREE_W*PREG_W-1:0]    i_free_preg,
    output logic [CNT_W-1:0]            o_free_count,
    output logic                        o_empty,
    output logic                        o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_PTR = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W+1)'(DEPTH);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              err;

    logic [PTR_W:0]    a_cnt;
    logic [PREG_W-1:0] a_preg [ALLOC_W];
    logic [CNT_W-1:0]  n_req;
    logic              grant;

    logic [PREG_W-1:0] fp [FREE_W];
    logic [PTR_W:0]    f_rank [FREE_W];
    logic [FREE_W-1:0] f_acc;
    logic [PTR_W:0]    f_cnt;
    logic              dup_err;

    logic [CNT_W:0]    after_alloc;
    logic [CNT_W:0]    cnt_sum;
    logic              ovf;
    logic [CNT_W-1:0]  count_nxt;

    // Offsets are always smaller than DEPTH, so one conditional subtract wraps.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, p} + off;
        if (s >= DEPTH_PTR) s = s - DEPTH_PTR;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        a_cnt = '0;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            a_preg[k] = mem[ptr_add(head, a_cnt)];
            if (i_alloc_req[k]) a_cnt = a_cnt + (PTR_W+1)'(1);
        end
    end

    assign n_req         = CNT_W'(a_cnt);
    assign grant         = (count >= n_req);
    assign o_alloc_grant = grant;
    assign o_stall       = (|i_alloc_req) & ~grant;
    assign o_free_count  = count;
    assign o_empty       = (count == '0);
    assign o_err         = err;

    always_comb begin
        o_alloc_preg = '0;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            if (i_alloc_req[k] && grant) o_alloc_preg[k*PREG_W +: PREG_W] = a_preg[k];
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < FREE_W; j++) fp[j] = i_free_preg[j*PREG_W +: PREG_W];
    end

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PREGS-1:0] in_pool;
    logic [NUM_PREGS-1:0] pool_nxt;
    logic                 clash;

    // A release is rejected if the preg is already pooled or an earlier port freed it this cycle.
    always_comb begin
        f_acc   = '0;
        f_cnt   = '0;
        dup_err = 1'b0;
        clash   = 1'b0;
        for (int unsigned j = 0; j < FREE_W; j++) begin
            f_rank[j] = f_cnt;
            if (i_free_valid[j] && fp[j] != '0) begin
                clash = in_pool[fp[j]];
                for (int unsigned i = 0; i < j; i++) begin
                    if (f_acc[i] && fp[i] == fp[j]) clash = 1'b1;
                end
                if (clash) begin
                    dup_err = 1'b1;
                end else begin
                    f_acc[j] = 1'b1;
                    f_cnt    = f_cnt + (PTR_W+1)'(1);
                end
            end
        end
    end

    always_comb begin
        pool_nxt = in_pool;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            if (grant && i_alloc_req[k]) pool_nxt[a_preg[k]] = 1'b0;
        end
        for (int unsigned j = 0; j < FREE_W; j++) begin
            if (!ovf && f_acc[j]) pool_nxt[fp[j]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) in_pool <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
        else       in_pool <= pool_nxt;
    end
`else
    always_comb begin
        f_acc   = '0;
        f_cnt   = '0;
        dup_err = 1'b0;
        for (int unsigned j = 0; j < FREE_W; j++) begin
            f_rank[j] = f_cnt;
            if (i_free_valid[j] && fp[j] != '0) begin
                f_acc[j] = 1'b1;
                f_cnt    = f_cnt + (PTR_W+1)'(1);
            end
        end
    end
`endif

    // Allocation is applied even when the releases of the same cycle overflow and are dropped.
    always_comb begin
        after_alloc = {1'b0, count} - (grant ? {1'b0, n_req} : '0);
        cnt_sum     = after_alloc + (CNT_W+1)'(f_cnt);
        ovf         = (cnt_sum > DEPTH_CNT);
        count_nxt   = ovf ? after_alloc[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(NUM_AREGS + i);
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            err   <= 1'b0;
        end else begin
            if (grant) head <= ptr_add(head, a_cnt);
            if (!ovf) begin
                for (int unsigned j = 0; j < FREE_W; j++) begin
                    if (f_acc[j]) mem[ptr_add(tail, f_rank[j])] <= fp[j];
                end
                tail <= ptr_add(tail, f_cnt);
            end
            count <= count_nxt;
            err   <= err | ovf | dup_err;
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list with a queue-based pool model checked every cycle.
module tb_preg_free_list;

    localparam int NP = 128;
    localparam int NA = 32;
    localparam int D  = 96;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_alloc_req;
    logic        o_alloc_grant;
    logic [13:0] o_alloc_preg;
    logic        o_stall;
    logic [2:0]  i_free_valid;
    logic [20:0] i_free_preg;
    logic [6:0]  o_free_count;
    logic        o_empty;
    logic        o_err;

    preg_free_list #(.NUM_PREGS(NP), .NUM_AREGS(NA), .ALLOC_W(2), .FREE_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_alloc_req(i_alloc_req), .o_alloc_grant(o_alloc_grant),
        .o_alloc_preg(o_alloc_preg), .o_stall(o_stall),
        .i_free_valid(i_free_valid), .i_free_preg(i_free_preg),
        .o_free_count(o_free_count), .o_empty(o_empty), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int pool[$];
    int held[$];
    bit m_err;
    bit inpool[NP];
    int n_checks = 0;
    int n_fail   = 0;
    int obs_p0, obs_p1, obs_grant, obs_stall, obs_count, obs_err, obs_empty;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pool.delete();
        held.delete();
        for (int i = 0; i < D; i++) pool.push_back(NA + i);
        for (int i = 0; i < NP; i++) inpool[i] = (i >= NA);
        m_err = 1'b0;
    endtask

    task automatic held_remove(input int v);
        for (int i = 0; i < held.size(); i++) begin
            if (held[i] == v) begin
                held.delete(i);
                return;
            end
        end
    endtask

    // One cycle: drive, compare outputs against the model mid-cycle, then advance the model.
    task automatic step(input logic [1:0] req, input logic [2:0] fv, input int f0, input int f1, input int f2);
        int nreq;
        int e0, e1;
        bit g;
        bit clash;
        int fp[3];
        int acc[$];
        i_alloc_req  = req;
        i_free_valid = fv;
        i_free_preg  = {7'(f2), 7'(f1), 7'(f0)};
        @(negedge i_clk);
        nreq = int'(req[0]) + int'(req[1]);
        g  = (pool.size() >= nreq);
        e0 = (g && req[0]) ? pool[0] : 0;
        e1 = (g && req[1]) ? pool[req[0] ? 1 : 0] : 0;
        obs_p0    = int'(o_alloc_preg[6:0]);
        obs_p1    = int'(o_alloc_preg[13:7]);
        obs_grant = int'(o_alloc_grant);
        obs_stall = int'(o_stall);
        obs_count = int'(o_free_count);
        obs_err   = int'(o_err);
        obs_empty = int'(o_empty);
        chk("grant", obs_grant, int'(g));
        chk("stall", obs_stall, int'((req != 2'b00) && !g));
        chk("preg0", obs_p0, e0);
        chk("preg1", obs_p1, e1);
        chk("count", obs_count, pool.size());
        chk("empty", obs_empty, int'(pool.size() == 0));
        chk("err", obs_err, int'(m_err));
        @(posedge i_clk);
        fp = '{f0, f1, f2};
        for (int j = 0; j < 3; j++) begin
            if (fv[j] && fp[j] != 0) begin
                clash = 1'b0;
`ifdef FREE_LIST_CHECK_EN
                if (inpool[fp[j]]) clash = 1'b1;
                foreach (acc[i]) if (acc[i] == fp[j]) clash = 1'b1;
`endif
                if (clash) m_err = 1'b1;
                else acc.push_back(fp[j]);
            end
        end
        if (g) begin
            for (int i = 0; i < nreq; i++) begin
                inpool[pool[0]] = 1'b0;
                held.push_back(pool.pop_front());
            end
        end
        if (pool.size() + acc.size() > D) begin
            m_err = 1'b1;
        end else begin
            foreach (acc[i]) begin
                pool.push_back(acc[i]);
                inpool[acc[i]] = 1'b1;
            end
        end
        #1;
    endtask

    // Reset is raised mid-cycle, away from any clock edge.
    task automatic do_reset();
        i_alloc_req  = '0;
        i_free_valid = '0;
        i_free_preg  = '0;
        i_rst = 1'b1;
        #2;
        chk("rst_count", int'(o_free_count), 96);
        chk("rst_err", int'(o_err), 0);
        chk("rst_empty", int'(o_empty), 0);
        chk("rst_grant", int'(o_alloc_grant), 1);
        chk("rst_stall", int'(o_stall), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int k;
        i_rst = 1'b1;
        i_alloc_req  = '0;
        i_free_valid = '0;
        i_free_preg  = '0;
        model_reset();
        #3;
        do_reset();

        // Basic pairs from reset
        step(2'b11, 3'b000, 0, 0, 0);
        chk("lit_p0_32", obs_p0, 32);
        chk("lit_p1_33", obs_p1, 33);
        step(2'b11, 3'b000, 0, 0, 0);
        chk("lit_cnt94", obs_count, 94);
        chk("lit_p0_34", obs_p0, 34);
        chk("lit_p1_35", obs_p1, 35);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_cnt92", obs_count, 92);

        // Single request on slot 1, then drain to one entry
        do_reset();
        step(2'b10, 3'b000, 0, 0, 0);
        chk("lit_s1_32", obs_p1, 32);
        chk("lit_s0_0", obs_p0, 0);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_cnt95", obs_count, 95);
        for (int i = 0; i < 47; i++) step(2'b11, 3'b000, 0, 0, 0);
        step(2'b11, 3'b000, 0, 0, 0);
        chk("lit_c1_grant", obs_grant, 0);
        chk("lit_c1_stall", obs_stall, 1);
        chk("lit_c1_cnt", obs_count, 1);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_c1_keep", obs_count, 1);
        step(2'b01, 3'b000, 0, 0, 0);
        chk("lit_last_127", obs_p0, 127);
        step(2'b01, 3'b001, 40, 0, 0);
        chk("lit_e_stall", obs_stall, 1);
        chk("lit_e_empty", obs_empty, 1);
        chk("lit_e_p0", obs_p0, 0);
        step(2'b01, 3'b000, 0, 0, 0);
        chk("lit_nobypass_40", obs_p0, 40);
        chk("lit_nb_grant", obs_grant, 1);

        // Simultaneous alloc/release at count 10, P0 dropped, head wrap
        do_reset();
        for (int i = 0; i < 43; i++) step(2'b11, 3'b000, 0, 0, 0);
        held_remove(50);
        held_remove(60);
        step(2'b11, 3'b111, 0, 50, 60);
        chk("lit_sim_cnt10", obs_count, 10);
        chk("lit_sim_118", obs_p0, 118);
        chk("lit_sim_119", obs_p1, 119);
        step(2'b11, 3'b000, 0, 0, 0);
        chk("lit_sim_keep10", obs_count, 10);
        for (int i = 0; i < 3; i++) step(2'b11, 3'b000, 0, 0, 0);
        step(2'b11, 3'b000, 0, 0, 0);
        chk("lit_sim_50", obs_p0, 50);
        chk("lit_sim_60", obs_p1, 60);

        // Steady traffic: tail wraps past entry 95
        for (int i = 0; i < 60; i++) begin
            int f[3];
            logic [2:0] v;
            v = '0;
            f = '{0, 0, 0};
            k = (held.size() < 3) ? held.size() : 3;
            for (int j = 0; j < k; j++) begin
                f[j] = held.pop_front();
                v[j] = 1'b1;
            end
            step(2'b11, v, f[0], f[1], f[2]);
        end

        // Overflow into a full pool
        do_reset();
        step(2'b00, 3'b001, 5, 0, 0);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_ovf_err", obs_err, 1);
        chk("lit_ovf_cnt", obs_count, 96);
        step(2'b11, 3'b000, 0, 0, 0);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_ovf_sticky", obs_err, 1);
        chk("lit_ovf_cnt94", obs_count, 94);

`ifdef FREE_LIST_CHECK_EN
        do_reset();
        step(2'b11, 3'b000, 0, 0, 0);
        step(2'b00, 3'b001, 33, 0, 0);
        step(2'b00, 3'b001, 33, 0, 0);
        chk("lit_df_ok", obs_err, 0);
        chk("lit_df_cnt95", obs_count, 95);
        step(2'b00, 3'b011, 32, 32, 0);
        chk("lit_df_err", obs_err, 1);
        chk("lit_df_keep95", obs_count, 95);
        step(2'b00, 3'b000, 0, 0, 0);
        chk("lit_dup_cnt96", obs_count, 96);
`endif

        // Reset in the middle of traffic
        step(2'b11, 3'b000, 0, 0, 0);
        step(2'b01, 3'b000, 0, 0, 0);
        do_reset();
        step(2'b01, 3'b000, 0, 0, 0);
        chk("lit_mid_32", obs_p0, 32);
        chk("lit_mid_cnt", obs_count, 96);
        chk("lit_mid_err", obs_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
